// File: rtl/phv_container_writer.sv
// Match-action write-back stage: substitutes up to six value fields into PHV
// containers chosen by a per-rule table entry and passes every other bit through.
module phv_container_writer #(
    parameter int STAGE             = 0,
    parameter int PHV_LEN           = 48*8+32*8+16*8+5*20+256,
    parameter int VAL_LEN           = 48*2+32*2+16*2,
    parameter int WB_OFF            = (3+1)*6,
    parameter int WB_OFF_ADDR_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PHV_LEN-1:0]           phv_in,
    input  logic                         phv_valid_in,
    input  logic [VAL_LEN-1:0]           val_in,
    input  logic [WB_OFF-1:0]            wb_off_entry_in,
    input  logic                         wb_off_entry_in_valid,
    input  logic [WB_OFF_ADDR_WIDTH-1:0] wb_off_entry_addr,
    output logic [PHV_LEN-1:0]           phv_out,
    output logic                         phv_valid_out
);

    localparam int TBL_DEPTH = 1 << WB_OFF_ADDR_WIDTH;
    localparam int OFF_6B    = 740;
    localparam int OFF_4B    = 484;
    localparam int OFF_2B    = 356;
    localparam int ADDR_LSB  = 140;

    logic [WB_OFF-1:0]  wb_table_r [TBL_DEPTH];
    logic [PHV_LEN-1:0] phv_s0_r;
    logic [VAL_LEN-1:0] val_s0_r;
    logic [WB_OFF-1:0]  entry_r;
    logic               vld_s0_r;
    logic [PHV_LEN-1:0] phv_s1_r;
    logic               vld_s1_r;
    logic [PHV_LEN-1:0] result_s;

    // Per-container mux; the A slot is tested first so it wins an index clash with B.
    function automatic logic [PHV_LEN-1:0] apply_wb(
        input logic [PHV_LEN-1:0] phv,
        input logic [VAL_LEN-1:0] val,
        input logic [WB_OFF-1:0]  entry
    );
        logic [PHV_LEN-1:0] r;
        r = phv;
        for (int k = 0; k < 8; k++) begin
            if (entry[23] && (entry[22:20] == 3'(k))) begin
                r[OFF_6B + 48*k +: 48] = val[191:144];
            end else if (entry[19] && (entry[18:16] == 3'(k))) begin
                r[OFF_6B + 48*k +: 48] = val[143:96];
            end else begin
                r[OFF_6B + 48*k +: 48] = phv[OFF_6B + 48*k +: 48];
            end
            if (entry[15] && (entry[14:12] == 3'(k))) begin
                r[OFF_4B + 32*k +: 32] = val[95:64];
            end else if (entry[11] && (entry[10:8] == 3'(k))) begin
                r[OFF_4B + 32*k +: 32] = val[63:32];
            end else begin
                r[OFF_4B + 32*k +: 32] = phv[OFF_4B + 32*k +: 32];
            end
            if (entry[7] && (entry[6:4] == 3'(k))) begin
                r[OFF_2B + 16*k +: 16] = val[31:16];
            end else if (entry[3] && (entry[2:0] == 3'(k))) begin
                r[OFF_2B + 16*k +: 16] = val[15:0];
            end else begin
                r[OFF_2B + 16*k +: 16] = phv[OFF_2B + 16*k +: 16];
            end
        end
        return r;
    endfunction

    // Write-back table storage; writes are independent of PHV traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                wb_table_r[i] <= {WB_OFF{1'b0}};
            end
        end else if (wb_off_entry_in_valid) begin
            wb_table_r[wb_off_entry_addr] <= wb_off_entry_in;
        end
    end

    // Stage 0: capture PHV/values and read the table (old entry on same-edge write).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_s0_r <= 1'b0;
            phv_s0_r <= {PHV_LEN{1'b0}};
            val_s0_r <= {VAL_LEN{1'b0}};
            entry_r  <= {WB_OFF{1'b0}};
        end else begin
            vld_s0_r <= phv_valid_in;
            if (phv_valid_in) begin
                phv_s0_r <= phv_in;
                val_s0_r <= val_in;
                entry_r  <= wb_table_r[phv_in[ADDR_LSB +: WB_OFF_ADDR_WIDTH]];
            end
        end
    end

    // Field substitution.
    always_comb begin
        result_s = apply_wb(phv_s0_r, val_s0_r, entry_r);
    end

    // Stage 1: register the substituted PHV.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_s1_r <= 1'b0;
            phv_s1_r <= {PHV_LEN{1'b0}};
        end else begin
            vld_s1_r <= vld_s0_r;
            if (vld_s0_r) begin
                phv_s1_r <= result_s;
            end
        end
    end

    // Output register; phv_out holds between valid pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phv_valid_out <= 1'b0;
            phv_out       <= {PHV_LEN{1'b0}};
        end else begin
            phv_valid_out <= vld_s1_r;
            if (vld_s1_r) begin
                phv_out <= phv_s1_r;
            end
        end
    end

endmodule

// File: tb/tb_phv_container_writer.sv
// Directed self-checking bench for phv_container_writer.
module tb_phv_container_writer;

    localparam int PHV_LEN = 1124;
    localparam int VAL_LEN = 192;
    localparam int WB_OFF  = 24;
    localparam int AW      = 4;

    logic               clk;
    logic               rst_n;
    logic [PHV_LEN-1:0] phv_in;
    logic               phv_valid_in;
    logic [VAL_LEN-1:0] val_in;
    logic [WB_OFF-1:0]  wb_off_entry_in;
    logic               wb_off_entry_in_valid;
    logic [AW-1:0]      wb_off_entry_addr;
    logic [PHV_LEN-1:0] phv_out;
    logic               phv_valid_out;

    int errors = 0;
    int checks = 0;

    phv_container_writer #(
        .STAGE(0), .PHV_LEN(PHV_LEN), .VAL_LEN(VAL_LEN),
        .WB_OFF(WB_OFF), .WB_OFF_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .phv_in(phv_in), .phv_valid_in(phv_valid_in), .val_in(val_in),
        .wb_off_entry_in(wb_off_entry_in),
        .wb_off_entry_in_valid(wb_off_entry_in_valid),
        .wb_off_entry_addr(wb_off_entry_addr),
        .phv_out(phv_out), .phv_valid_out(phv_valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PHV_LEN-1:0] mk_phv(input logic [31:0] seed, input logic [3:0] addr);
        logic [PHV_LEN-1:0] r;
        logic [31:0] w;
        for (int i = 0; i < PHV_LEN; i++) begin
            w = seed ^ (32'(i / 32) * 32'h9E3779B9);
            r[i] = w[i % 32];
        end
        r[143:140] = addr;
        return r;
    endfunction

    task automatic write_entry(input logic [AW-1:0] addr, input logic [WB_OFF-1:0] entry);
        wb_off_entry_addr     = addr;
        wb_off_entry_in       = entry;
        wb_off_entry_in_valid = 1'b1;
        tick();
        wb_off_entry_in_valid = 1'b0;
    endtask

    // Sends one PHV and samples valid after edges N+1, N+2, N+3 plus data after N+2 and N+3.
    task automatic run_phv(input logic [PHV_LEN-1:0] p, input logic [VAL_LEN-1:0] v,
                           output logic v1, output logic v2, output logic v3,
                           output logic [PHV_LEN-1:0] got, output logic [PHV_LEN-1:0] held);
        phv_in       = p;
        val_in       = v;
        phv_valid_in = 1'b1;
        tick();
        phv_valid_in = 1'b0;
        tick();
        v1 = phv_valid_out;
        tick();
        v2  = phv_valid_out;
        got = phv_out;
        tick();
        v3   = phv_valid_out;
        held = phv_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        phv_in = '0; val_in = '0; phv_valid_in = 1'b0;
        wb_off_entry_in = '0; wb_off_entry_in_valid = 1'b0; wb_off_entry_addr = '0;
        tick(); tick();
        checks++;
        if (phv_valid_out !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", phv_valid_out);
        end
        checks++;
        if (phv_out !== {PHV_LEN{1'b0}}) begin
            errors++; $display("FAIL reset_phv_out: got %h want 0", phv_out);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pass_through();
        logic [PHV_LEN-1:0] p, got, held;
        logic v1, v2, v3;
        p = mk_phv(32'h1357_9BDF, 4'd9);
        p[1123:1076] = 48'hffffffffffff;
        p[1075:1028] = 48'heeeeeeeeeeee;
        p[739:708]   = 32'hcccccccc;
        run_phv(p, {VAL_LEN{1'b1}}, v1, v2, v3, got, held);
        checks++;
        if (v1 !== 1'b0) begin errors++; $display("FAIL pt_early_valid: got %b want 0", v1); end
        checks++;
        if (v2 !== 1'b1) begin errors++; $display("FAIL pt_valid: got %b want 1", v2); end
        checks++;
        if (got !== p) begin errors++; $display("FAIL pt_data: got %h want %h", got, p); end
        checks++;
        if (v3 !== 1'b0) begin errors++; $display("FAIL pt_pulse: got %b want 0", v3); end
        checks++;
        if (held !== p) begin errors++; $display("FAIL pt_hold: got %h want %h", held, p); end
    endtask

    task automatic test_single_slot();
        logic [PHV_LEN-1:0] p, exp, got, held;
        logic [VAL_LEN-1:0] v;
        logic v1, v2, v3;
        write_entry(4'd0, 24'h800000);
        p = mk_phv(32'h2468_ACE0, 4'd0);
        v = {VAL_LEN{1'b0}};
        v[191:144] = 48'h123456789abc;
        v[143:96]  = 48'h0f0f0f0f0f0f;
        exp = p;
        exp[787:740] = 48'h123456789abc;
        run_phv(p, v, v1, v2, v3, got, held);
        checks++;
        if (v2 !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", v2); end
        checks++;
        if (got !== exp) begin errors++; $display("FAIL single_data: got %h want %h", got, exp); end
    endtask

    task automatic test_all_slots();
        logic [PHV_LEN-1:0] p, exp, got, held;
        logic [VAL_LEN-1:0] v;
        logic v1, v2, v3;
        write_entry(4'd3, {4'hF, 4'hE, 4'hF, 4'hE, 4'hF, 4'hE});
        p = mk_phv(32'hCAFE_F00D, 4'd3);
        v = {48'hA1A1A1A1A1A1, 48'hB2B2B2B2B2B2, 32'hC3C3C3C3, 32'hD4D4D4D4, 16'hE5E5, 16'hF6F6};
        exp = p;
        exp[1123:1076] = 48'hA1A1A1A1A1A1;
        exp[1075:1028] = 48'hB2B2B2B2B2B2;
        exp[739:708]   = 32'hC3C3C3C3;
        exp[707:676]   = 32'hD4D4D4D4;
        exp[483:468]   = 16'hE5E5;
        exp[467:452]   = 16'hF6F6;
        run_phv(p, v, v1, v2, v3, got, held);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL all_slots_data: got %h want %h", got, exp); end
        checks++;
        if (got[355:0] !== p[355:0]) begin
            errors++; $display("FAIL all_slots_meta: got %h want %h", got[355:0], p[355:0]);
        end
    endtask

    task automatic test_conflict();
        logic [PHV_LEN-1:0] p, exp, got, held;
        logic [VAL_LEN-1:0] v;
        logic v1, v2, v3;
        write_entry(4'd1, 24'h00AA00);
        p = mk_phv(32'h0BAD_BEEF, 4'd1);
        v = {VAL_LEN{1'b0}};
        v[95:64] = 32'h11111111;
        v[63:32] = 32'h22222222;
        exp = p;
        exp[579:548] = 32'h11111111;
        run_phv(p, v, v1, v2, v3, got, held);
        checks++;
        if (got[579:548] !== 32'h11111111) begin
            errors++; $display("FAIL conflict_4b_c2: got %h want 11111111", got[579:548]);
        end
        checks++;
        if (got !== exp) begin errors++; $display("FAIL conflict_data: got %h want %h", got, exp); end
    endtask

    task automatic test_back_to_back();
        logic [PHV_LEN-1:0] p0, p1, p2, e1;
        logic [VAL_LEN-1:0] v;
        write_entry(4'd0, 24'h000000);
        p0 = mk_phv(32'h1111_0000, 4'd5);
        p1 = mk_phv(32'h2222_0000, 4'd5);
        p2 = mk_phv(32'h3333_0000, 4'd0);
        v = {VAL_LEN{1'b0}};
        v[191:144] = 48'hdeadbeef0001;
        e1 = p1;
        e1[787:740] = 48'hdeadbeef0001;
        // P0 and the table write to its address share edge N.
        wb_off_entry_addr = 4'd5; wb_off_entry_in = 24'h800000; wb_off_entry_in_valid = 1'b1;
        phv_in = p0; val_in = v; phv_valid_in = 1'b1;
        tick();
        wb_off_entry_in_valid = 1'b0;
        phv_in = p1;
        tick();
        checks++;
        if (phv_valid_out !== 1'b0) begin errors++; $display("FAIL b2b_early: got %b want 0", phv_valid_out); end
        phv_in = p2;
        tick();
        phv_valid_in = 1'b0;
        checks++;
        if (phv_valid_out !== 1'b1 || phv_out !== p0) begin
            errors++; $display("FAIL b2b_p0: valid %b got %h want %h", phv_valid_out, phv_out, p0);
        end
        tick();
        checks++;
        if (phv_valid_out !== 1'b1 || phv_out !== e1) begin
            errors++; $display("FAIL b2b_p1: valid %b got %h want %h", phv_valid_out, phv_out, e1);
        end
        tick();
        checks++;
        if (phv_valid_out !== 1'b1 || phv_out !== p2) begin
            errors++; $display("FAIL b2b_p2: valid %b got %h want %h", phv_valid_out, phv_out, p2);
        end
        tick();
        checks++;
        if (phv_valid_out !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b want 0", phv_valid_out); end
    endtask

    task automatic test_reset_mid_flight();
        logic [PHV_LEN-1:0] p, got, held;
        logic [VAL_LEN-1:0] v;
        logic v1, v2, v3;
        int seen;
        p = mk_phv(32'h4444_5555, 4'd5);
        v = {VAL_LEN{1'b1}};
        phv_in = p; val_in = v; phv_valid_in = 1'b1;
        tick();
        phv_valid_in = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (phv_out !== {PHV_LEN{1'b0}}) begin
            errors++; $display("FAIL midrst_phv_out: got %h want 0", phv_out);
        end
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (phv_valid_out !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midrst_no_output: got %0d pulses want 0", seen); end
        // Address 5 held a 6B-A write entry before reset; the table is now cleared.
        run_phv(p, v, v1, v2, v3, got, held);
        checks++;
        if (v2 !== 1'b1 || got !== p) begin
            errors++; $display("FAIL midrst_cleared: valid %b got %h want %h", v2, got, p);
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_single_slot();
        test_all_slots();
        test_conflict();
        test_back_to_back();
        test_reset_mid_flight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
